// File: rtl/mmio_gpio.sv
`default_nettype none
// ============================================================================
// mmio_gpio : memory-mapped LED / debounced-switch GPIO with change interrupt
// Rev 1.0
// ============================================================================
module mmio_gpio #(
   parameter logic [15:0] BASE_ADDR = 16'hC000,
   parameter int          LED_W     = 10,
   parameter int          SW_W      = 10,
   parameter int          DB_CYCLES = 50000,
   parameter logic [15:0] BAD_DATA  = 16'hDEAD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      addr,
   input  logic             re,
   input  logic             we,
   input  logic [15:0]      wdata,
   output logic [15:0]      rdata,
   input  logic [SW_W-1:0]  sw,
   output logic [LED_W-1:0] led,
   output logic             irq
);

   localparam int                 c_cnt_w  = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_db_max = c_cnt_w'(DB_CYCLES - 1);

   logic [SW_W-1:0]    r_sync1, r_sw_s, r_sw_prev, r_sw_db, r_chg, r_irq_en;
   logic [LED_W-1:0]   r_led;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_primed, r_irq;

   logic [15:0]        w_off;
   logic               w_hit, w_wr, w_stable, w_sat, w_load;
   logic [SW_W-1:0]    w_set, w_clr, w_chg_next, w_irq_en_next;
   logic               w_unused;

   assign w_off    = addr - BASE_ADDR;
   assign w_hit    = (w_off < 16'd4);
   assign w_wr     = we & w_hit;
   assign w_unused = &{1'b0, wdata};

   // A load needs the synchronised value to have held steady for the full window.
   assign w_stable = (r_sw_s == r_sw_prev);
   assign w_sat    = w_stable && (r_cnt == c_db_max);
   assign w_load   = w_sat && (r_sw_s != r_sw_db);

   assign w_set         = (w_load && r_primed) ? (r_sw_s ^ r_sw_db) : '0;
   assign w_clr         = (w_wr && (w_off[1:0] == 2'd2)) ? wdata[SW_W-1:0] : '0;
   assign w_chg_next    = (r_chg & ~w_clr) | w_set;
   assign w_irq_en_next = (w_wr && (w_off[1:0] == 2'd3)) ? wdata[SW_W-1:0] : r_irq_en;

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         r_sync1   <= '0;
         r_sw_s    <= '0;
         r_sw_prev <= '0;
         r_sw_db   <= '0;
         r_chg     <= '0;
         r_irq_en  <= '0;
         r_led     <= '0;
         r_cnt     <= '0;
         r_primed  <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         r_sync1   <= sw;
         r_sw_s    <= r_sync1;
         r_sw_prev <= r_sw_s;
         if (!w_stable)
            r_cnt <= '0;
         else if (r_cnt != c_db_max)
            r_cnt <= r_cnt + c_cnt_w'(1);
         if (w_sat)
            r_primed <= 1'b1;
         if (w_load)
            r_sw_db <= r_sw_s;
         if (w_wr && (w_off[1:0] == 2'd0))
            r_led <= wdata[LED_W-1:0];
         r_chg    <= w_chg_next;
         r_irq_en <= w_irq_en_next;
         r_irq    <= |(w_chg_next & w_irq_en_next);
      end
   end

   always_comb begin
      rdata = BAD_DATA;
      if (re && w_hit) begin
         rdata = '0;
         case (w_off[1:0])
            2'd0:    rdata[LED_W-1:0] = r_led;
            2'd1:    rdata[SW_W-1:0]  = r_sw_db;
            2'd2:    rdata[SW_W-1:0]  = r_chg;
            default: rdata[SW_W-1:0]  = r_irq_en;
         endcase
      end
   end

   assign led = r_led;
   assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_mmio_gpio.sv
`default_nettype none
// tb_mmio_gpio : directed + randomized bench for mmio_gpio with DB_CYCLES=4,
// checked against a register/settled-switch level model.
module tb_mmio_gpio;
   localparam int          DB   = 4;
   localparam logic [15:0] BASE = 16'hC000;
   localparam int          HOLD = 12;

   logic        clk = 1'b0;
   logic        rst, re, we;
   logic [15:0] addr, wdata, rdata;
   logic [9:0]  sw, led;
   logic        irq;

   int passed = 0;
   int total  = 0;
   int lat    = 0;

   logic [9:0] m_led, m_sw_db, m_chg, m_irq_en;
   bit         m_primed;

   mmio_gpio #(.BASE_ADDR(BASE), .LED_W(10), .SW_W(10), .DB_CYCLES(DB), .BAD_DATA(16'hDEAD)) dut (
      .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we), .wdata(wdata),
      .rdata(rdata), .sw(sw), .led(led), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [15:0] model_reg(input int o);
      case (o)
         0:       return {6'b0, m_led};
         1:       return {6'b0, m_sw_db};
         2:       return {6'b0, m_chg};
         default: return {6'b0, m_irq_en};
      endcase
   endfunction

   function automatic logic model_irq();
      return |(m_chg & m_irq_en);
   endfunction

   task automatic model_reset();
      m_led = '0; m_sw_db = '0; m_chg = '0; m_irq_en = '0; m_primed = 0;
   endtask

   // Switch value has been held long enough to be accepted.
   task automatic model_settle(input logic [9:0] v);
      if (v != m_sw_db) begin
         if (m_primed) m_chg |= v ^ m_sw_db;
         m_sw_db = v;
      end
      m_primed = 1;
   endtask

   task automatic peek(input logic [15:0] a, input logic [15:0] exp, input string tag);
      addr = a; re = 1'b1;
      #1;
      check(tag, rdata, exp);
      re = 1'b0;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      logic [15:0] off;
      @(posedge clk); #1;
      addr = a; wdata = d; we = 1'b1;
      @(negedge clk); #1;
      we = 1'b0;
      off = a - BASE;
      case (off)
         16'd0:   m_led = d[9:0];
         16'd2:   m_chg &= ~d[9:0];
         16'd3:   m_irq_en = d[9:0];
         default: ;
      endcase
   endtask

   task automatic check_outs(input string tag);
      check({tag, "_led"}, {6'b0, led}, {6'b0, m_led});
      check({tag, "_irq"}, {15'b0, irq}, {15'b0, model_irq()});
   endtask

   task automatic set_sw(input logic [9:0] v);
      @(posedge clk); #1;
      sw = v;
   endtask

   task automatic bounce_to(input logic [9:0] fin);
      logic [9:0] v;
      v = sw;
      for (int k = 0; k < int'($urandom_range(3, 8)); k++) begin
         v = v ^ 10'($urandom_range(1, 1023));
         set_sw(v);
         repeat ($urandom_range(0, 1)) @(posedge clk);
      end
      set_sw(fin);
      repeat (HOLD) @(posedge clk);
      model_settle(fin);
   endtask

   task automatic rand_op();
      int          kind;
      logic [15:0] d, oor;
      kind = $urandom_range(0, 5);
      d    = 16'($urandom);
      oor  = ($urandom_range(0, 1) == 0) ? 16'hC004 + 16'($urandom_range(0, 11))
                                         : 16'hBFF0 + 16'($urandom_range(0, 15));
      case (kind)
         0: wr(BASE, d);
         1: wr(BASE + 16'd3, d);
         2: wr(BASE + 16'd2, d);
         3: wr(BASE + 16'd1, d);
         4: wr(oor, d);
         default: begin
            @(posedge clk); #1;
            addr = BASE; wdata = d; we = 1'b1; re = 1'b1;
            #1;
            check("rw_led_old", rdata, {6'b0, m_led});
            @(negedge clk); #1;
            we = 1'b0; re = 1'b0;
            m_led = d[9:0];
         end
      endcase
      check_outs("rop");
      begin
         int o;
         o = $urandom_range(0, 3);
         peek(BASE + 16'(o), model_reg(o), "rop_rd");
      end
   endtask

   initial begin
      logic [15:0] got;
      rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wdata = '0; sw = '0;
      model_reset();

      // Reset state and read decode
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int o = 0; o < 4; o++) peek(BASE + 16'(o), 16'h0000, "rst_rd");
      check("rst_irq", {15'b0, irq}, 16'h0000);
      check("rst_led", {6'b0, led}, 16'h0000);
      peek(16'hC004, 16'hDEAD, "oor_rd");
      addr = 16'hC001; re = 1'b0; #1;
      check("re0_rd", rdata, 16'hDEAD);
      repeat (HOLD) @(posedge clk);
      model_settle(10'h000);

      // LED register
      wr(16'hC000, 16'hFFFF);
      check("led_ffff", {6'b0, led}, 16'h03FF);
      peek(16'hC000, 16'h03FF, "led_rd");
      wr(16'hC005, 16'h0155);
      check("led_oor", {6'b0, led}, 16'h03FF);

      // Bounce shorter than the window never reaches sw_db
      for (int i = 0; i < 10; i++) begin
         set_sw((i % 2 == 0) ? 10'h001 : 10'h000);
         peek(16'hC001, {6'b0, m_sw_db}, "bounce_sw");
         @(posedge clk);
      end
      set_sw(10'h001);
      repeat (HOLD) @(posedge clk);
      model_settle(10'h001);
      peek(16'hC001, 16'h0001, "db_sw");
      peek(16'hC002, 16'h0001, "db_chg");

      // Power-up switch positions are learned silently
      @(posedge clk); #1;
      rst = 1'b1; sw = 10'h2A0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (HOLD) @(posedge clk);
      model_settle(10'h2A0);
      peek(16'hC001, 16'h02A0, "prime_sw");
      peek(16'hC002, 16'h0000, "prime_chg");
      check("prime_irq", {15'b0, irq}, 16'h0000);

      // Interrupt and W1C
      wr(16'hC003, 16'h0001);
      set_sw(10'h2A1);
      repeat (HOLD) @(posedge clk);
      model_settle(10'h2A1);
      check("irq_set", {15'b0, irq}, 16'h0001);
      wr(16'hC002, 16'h0001);
      peek(16'hC002, 16'h0000, "w1c_chg");
      check("w1c_irq", {15'b0, irq}, 16'h0000);

      // Measure change-to-sw_db latency on bit 1
      set_sw(10'h2A3);
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         @(posedge clk); #1;
         addr = 16'hC001; re = 1'b1; #1;
         got = rdata; re = 1'b0;
         lat = n;
         if (got == 16'h02A3) break;
      end
      check("db_latency_ok", {15'b0, (lat >= 2 + DB - 1 && lat <= 2 + DB + 1)}, 16'h0001);
      model_settle(10'h2A3);
      wr(16'hC002, 16'h03FF);

      // W1C landing on the same cycle as a new change: set wins
      set_sw(10'h2A2);
      repeat (lat - 1) @(negedge clk);
      @(posedge clk); #1;
      addr = 16'hC002; wdata = 16'h0001; we = 1'b1;
      @(negedge clk); #1;
      we = 1'b0;
      model_settle(10'h2A2);
      peek(16'hC002, 16'h0001, "setwins_chg");
      check("setwins_irq", {15'b0, irq}, 16'h0001);
      wr(16'hC002, 16'h0001);
      check_outs("clr");

      // Randomized episodes
      for (int e = 0; e < 10; e++) begin
         bounce_to(10'($urandom_range(0, 1023)));
         peek(16'hC001, {6'b0, m_sw_db}, "ep_sw");
         peek(16'hC002, {6'b0, m_chg}, "ep_chg");
         check_outs("ep");
         for (int k = 0; k < 6; k++) rand_op();
      end

      // Asynchronous reset in the middle of a bounce
      wr(16'hC000, 16'h0155);
      wr(16'hC003, 16'h03FF);
      wr(16'hC002, 16'h03FF);
      bounce_to(~sw);
      check("pre_rst_irq", {15'b0, irq}, 16'h0001);
      set_sw(sw ^ 10'h00F);
      @(posedge clk); #1;
      sw = sw ^ 10'h0F0;
      #1 rst = 1'b1;
      model_reset();
      #1;
      check("arst_led", {6'b0, led}, 16'h0000);
      check("arst_irq", {15'b0, irq}, 16'h0000);
      for (int o = 0; o < 4; o++) peek(BASE + 16'(o), 16'h0000, "arst_rd");
      @(posedge clk); #1;
      sw = 10'h15A;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (HOLD) @(posedge clk);
      model_settle(10'h15A);
      peek(16'hC001, 16'h015A, "relearn_sw");
      peek(16'hC002, 16'h0000, "relearn_chg");
      check_outs("relearn");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
